// File: rtl/hs_pkg.sv
// Shared definitions for the high-speed sender/receiver link blocks.
package hs_pkg;

    localparam int unsigned HS_DATA_W     = 16;
    localparam int unsigned HS_BEAT_CNT_W = 16;
    localparam int unsigned HS_DEPTH      = 4;

    // Pointer width for a power-of-two buffer; a single-entry buffer still needs one bit.
    function automatic int unsigned hs_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned HS_PTR_W = hs_ptr_w(HS_DEPTH);

    typedef struct packed {
        logic wr;
        logic drop;
    } hs_fifo_op_t;

endpackage

// File: rtl/hs_rx_fifo.sv
// First-word-fall-through circular buffer: storage, pointers and occupancy.
// Reports which operations took effect so the parent can track errors/counts.
module hs_rx_fifo
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W = HS_DATA_W,
    parameter int unsigned DEPTH  = HS_DEPTH,
    localparam int unsigned PTR_W = hs_ptr_w(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_req_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  count_nxt_o,
    output hs_fifo_op_t       op_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en, rd_en;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_en    = pop_req_i && (count_q != '0);
        // A full buffer still accepts a beat when the head retires on the same edge.
        wr_en    = push_i && ((count_q != CNT_W'(DEPTH)) || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o      = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_o = count_d;
    assign op_o        = '{wr: wr_en, drop: push_i && !wr_en};

endmodule

// File: rtl/hs_rx_buffer.sv
// Receive-side elastic buffer: absorbs beats still in flight after ready drops,
// and tracks a sticky overflow flag plus a wrapping accepted-beat counter.
module hs_rx_buffer
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W    = HS_DATA_W,
    parameter int unsigned DEPTH     = HS_DEPTH,
    parameter int unsigned READY_LAG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data,
    input  logic                     valid,
    output logic                     ready,
    output logic [DATA_W-1:0]        data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [HS_BEAT_CNT_W-1:0] beat_cnt
);

    localparam int unsigned CNT_W = hs_ptr_w(DEPTH) + 1;
    // (DEPTH - count) > READY_LAG+1 rewritten as a plain compare against a constant.
    localparam int unsigned READY_LIMIT = DEPTH - READY_LAG - 1;

    logic [CNT_W-1:0]         count, count_nxt;
    hs_fifo_op_t              op;
    logic                     ready_q, ready_d;
    logic                     overflow_q, overflow_d;
    logic [HS_BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    hs_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (valid),
        .pop_req_i   (out_ready),
        .data_i      (data),
        .data_o      (data_out),
        .count_o     (count),
        .count_nxt_o (count_nxt),
        .op_o        (op)
    );

    always_comb begin
        ready_d    = count_nxt < CNT_W'(READY_LIMIT);
        overflow_d = overflow_q | op.drop;
        beat_cnt_d = op.wr ? beat_cnt_q + HS_BEAT_CNT_W'(1) : beat_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign ready     = ready_q;
    assign out_valid = (count != '0);
    assign overflow  = overflow_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_hs_rx_buffer.sv
// Self-checking bench for hs_rx_buffer: vector table, queue scoreboard and
// hand-written sequences through a registered sender model.
module tb_hs_rx_buffer;

    localparam int DEPTH = 4;
    localparam int LAG   = 1;

    logic        clk;
    logic        rst;
    logic [15:0] data_w;
    logic        valid_w;
    logic        ready;
    logic [15:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [15:0] beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Direct drive versus registered sender model.
    logic        use_snd = 1'b0;
    logic        drv_vld = 1'b0;
    logic [15:0] drv_dat = '0;

    // Sender: sees ready one register late, and its valid/data are registered too.
    logic        snd_on   = 1'b0;
    logic        snd_load = 1'b1;
    logic [15:0] snd_base = 16'h0001;
    logic [15:0] snd_limit = 16'd0;
    logic        rdy_seen;
    logic        snd_vld;
    logic [15:0] snd_dat;
    logic [15:0] snd_next;
    logic [15:0] snd_issued;

    assign valid_w = use_snd ? snd_vld : drv_vld;
    assign data_w  = use_snd ? snd_dat : drv_dat;

    hs_rx_buffer #(
        .DATA_W    (16),
        .DEPTH     (DEPTH),
        .READY_LAG (LAG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data_w),
        .valid     (valid_w),
        .ready     (ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        rdy_seen <= ready;
        if (snd_load) begin
            snd_next   <= snd_base;
            snd_issued <= '0;
            snd_vld    <= 1'b0;
        end else if (snd_on && rdy_seen && (snd_issued < snd_limit)) begin
            snd_vld    <= 1'b1;
            snd_dat    <= snd_next;
            snd_next   <= snd_next + 16'd1;
            snd_issued <= snd_issued + 16'd1;
        end else begin
            snd_vld <= 1'b0;
        end
    end

    // Scoreboard model: queue of expected head data plus flag/counter state.
    logic [15:0] mq[$];
    logic        m_ovf;
    logic        m_rdy;
    logic [15:0] m_cnt;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin : model
        logic m_pop;
        logic m_acc;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cnt = '0;
            m_rdy = 1'b1;
        end else begin
            m_pop = (mq.size() != 0) && out_ready;
            m_acc = valid_w && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                mq.push_back(data_w);
                m_cnt = m_cnt + 16'd1;
            end else if (valid_w) begin
                m_ovf = 1'b1;
            end
            m_rdy = (DEPTH - mq.size()) > (LAG + 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sb out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) check("sb data_out", data_out, mq[0]);
            check("sb ready", ready, m_rdy);
            check("sb overflow", overflow, m_ovf);
            check("sb beat_cnt", beat_cnt, m_cnt);
        end
    end

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [15:0] data;
        logic        out_ready;
        logic        exp_ov;
        logic [15:0] exp_data;
        logic        exp_rdy;
        logic        exp_ovf;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    task automatic do_reset();
        rst       = 1'b1;
        drv_vld   = 1'b0;
        out_ready = 1'b0;
        use_snd   = 1'b0;
        snd_on    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] got[$];
    logic [15:0] exp_drain[4];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'hA001, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b0, 16'd1};
        vecs[1]  = '{1'b0, 1'b1, 16'hA002, 1'b0, 1'b1, 16'hA001, 1'b0, 1'b0, 16'd2};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA002, 1'b1, 1'b0, 16'd2};
        vecs[3]  = '{1'b0, 1'b1, 16'hA003, 1'b1, 1'b1, 16'hA003, 1'b1, 1'b0, 16'd3};
        vecs[4]  = '{1'b0, 1'b1, 16'hA004, 1'b0, 1'b1, 16'hA003, 1'b0, 1'b0, 16'd4};
        vecs[5]  = '{1'b0, 1'b1, 16'hA005, 1'b0, 1'b1, 16'hA003, 1'b0, 1'b0, 16'd5};
        vecs[6]  = '{1'b0, 1'b1, 16'hA006, 1'b0, 1'b1, 16'hA003, 1'b0, 1'b0, 16'd6};
        vecs[7]  = '{1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b1, 16'hA003, 1'b0, 1'b1, 16'd6};
        vecs[8]  = '{1'b0, 1'b1, 16'hA007, 1'b1, 1'b1, 16'hA004, 1'b0, 1'b1, 16'd7};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA005, 1'b0, 1'b1, 16'd7};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA006, 1'b0, 1'b1, 16'd7};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA007, 1'b1, 1'b1, 16'd7};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd7};
        vecs[13] = '{1'b0, 1'b1, 16'hB001, 1'b1, 1'b1, 16'hB001, 1'b1, 1'b1, 16'd8};
        vecs[14] = '{1'b1, 1'b1, 16'hB002, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
        vecs[15] = '{1'b0, 1'b1, 16'hB003, 1'b0, 1'b1, 16'hB003, 1'b1, 1'b0, 16'd1};

        // Reset state.
        rst       = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset ready", ready, 1);
        check("reset overflow", overflow, 0);
        check("reset beat_cnt", beat_cnt, 0);
        chk_en   = 1'b1;
        rst      = 1'b0;
        snd_load = 1'b0;

        // Vector table.
        for (int i = 0; i < NVEC; i++) begin
            rst       = vecs[i].rst;
            drv_vld   = vecs[i].valid;
            drv_dat   = vecs[i].data;
            out_ready = vecs[i].out_ready;
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_ov);
            if (vecs[i].exp_ov) check($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_data);
            check($sformatf("vec%0d ready", i), ready, vecs[i].exp_rdy);
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].exp_ovf);
            check($sformatf("vec%0d beat_cnt", i), beat_cnt, vecs[i].exp_cnt);
        end
        rst = 1'b0;

        // Stream 0x0001..0x0010 with the consumer always ready.
        do_reset();
        repeat (2) @(negedge clk);
        snd_base  = 16'h0001;
        snd_limit = 16'd16;
        snd_load  = 1'b1;
        @(negedge clk);
        snd_load  = 1'b0;
        use_snd   = 1'b1;
        out_ready = 1'b1;
        snd_on    = 1'b1;
        got.delete();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check("stream ready", ready, 1);
            if (out_valid && out_ready) got.push_back(data_out);
        end
        check("stream beats", got.size(), 16);
        for (int i = 0; i < got.size(); i++) check($sformatf("stream beat%0d", i), got[i], i + 1);
        check("stream beat_cnt", beat_cnt, 16);
        check("stream overflow", overflow, 0);

        // Continuous valid, consumer stalled: in-flight beats absorbed.
        do_reset();
        repeat (2) @(negedge clk);
        snd_base  = 16'h0101;
        snd_limit = 16'd100;
        snd_load  = 1'b1;
        @(negedge clk);
        snd_load = 1'b0;
        use_snd  = 1'b1;
        snd_on   = 1'b1;
        repeat (10) @(negedge clk);
        snd_on = 1'b0;
        @(negedge clk);
        check("stall issued", snd_issued, 4);
        check("stall beat_cnt", beat_cnt, 4);
        check("stall overflow", overflow, 0);
        check("stall ready", ready, 0);
        check("stall head", data_out, 16'h0101);
        use_snd = 1'b0;

        // Full buffer, push and pop on the same edge.
        drv_vld   = 1'b1;
        drv_dat   = 16'h0200;
        out_ready = 1'b1;
        @(negedge clk);
        drv_vld   = 1'b0;
        out_ready = 1'b0;
        check("fullpp beat_cnt", beat_cnt, 5);
        check("fullpp overflow", overflow, 0);
        check("fullpp head", data_out, 16'h0102);
        check("fullpp ready", ready, 0);

        // Full buffer, consumer stalled: 0xDEAD dropped.
        drv_vld = 1'b1;
        drv_dat = 16'hDEAD;
        @(negedge clk);
        drv_vld = 1'b0;
        check("drop overflow", overflow, 1);
        check("drop beat_cnt", beat_cnt, 5);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 6; c++) begin
            if (out_valid && out_ready) got.push_back(data_out);
            @(negedge clk);
        end
        out_ready = 1'b0;
        exp_drain = '{16'h0102, 16'h0103, 16'h0104, 16'h0200};
        check("drain beats", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check($sformatf("drain beat%0d", i), got[i], exp_drain[i]);
        check("drain overflow held", overflow, 1);
        check("drain empty", out_valid, 0);

        // Beat counter wrap after 65535 + 1 accepted beats.
        do_reset();
        out_ready = 1'b1;
        drv_vld   = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drv_dat = 16'(i);
            @(negedge clk);
        end
        check("wrap beat_cnt ffff", beat_cnt, 16'hFFFF);
        drv_dat = 16'h7777;
        @(negedge clk);
        check("wrap beat_cnt 0", beat_cnt, 16'h0000);

        // Fill to 4 with a drop, retire one (count 3), then reset mid-transfer.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drv_dat = 16'h0300 + 16'(k);
            @(negedge clk);
        end
        drv_vld   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("prerst overflow", overflow, 1);
        check("prerst beat_cnt", beat_cnt, 3);
        rst       = 1'b1;
        drv_vld   = 1'b1;
        drv_dat   = 16'hBAD0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst out_valid", out_valid, 0);
        check("midrst ready", ready, 1);
        check("midrst overflow", overflow, 0);
        check("midrst beat_cnt", beat_cnt, 0);
        rst       = 1'b0;
        drv_dat   = 16'h0055;
        out_ready = 1'b0;
        @(negedge clk);
        drv_vld = 1'b0;
        check("postrst out_valid", out_valid, 1);
        check("postrst head", data_out, 16'h0055);
        check("postrst beat_cnt", beat_cnt, 1);
        @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
